data_mem_copy_engine: RTL and testbench

Word-copy DMA master for the data memory port. Once started, it copies `i_len` 32-bit words from a source byte address to a destination byte address, one word at a time. It drives the same address / write-data / read / write strobe signals the data memory consumes, and samples that memory's combinational read data. It sits beside the pipeline's MEM stage, and an external arbiter grants it the memory port cycle by cycle.

---
 rtl/data_mem_copy_engine.sv | 144 ++++++++++++++
 tb/tb_data_mem_copy_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_copy_engine.sv
// data_mem_copy_engine
// Word-copy DMA master sharing the data memory port with the MEM stage.
// It alternates one read and one write per word, in ascending address order.
// The grant arrives combinationally with the request. Because of this, the memory
// strobes, address and write data are decoded from the registered state and the
// current grant in the same cycle. All other state is held in registers.
module data_mem_copy_engine #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [31:0]          i_src,
  input  logic [31:0]          i_dst,
  input  logic [LEN_WIDTH-1:0] i_len,
  input  logic                 i_grant,
  input  logic [31:0]          i_mem_read_data,
  output logic                 o_req,
  output logic [31:0]          o_address,
  output logic [31:0]          o_mem_write_data,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [LEN_WIDTH-1:0] o_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [31:0]          WORD_MASK = 32'hFFFF_FFFC;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [31:0]            r_src;
  logic [31:0]            r_dst;
  logic [31:0]            r_buffer;
  logic [LEN_WIDTH-1:0]   r_remaining;
  logic [LEN_WIDTH-1:0]   r_count;

  assign o_count = r_count;

  // Next-state and port decode. Reset suppresses any access in the current cycle.
  always_comb begin
    w_next_state     = r_state;
    o_req            = 1'b0;
    o_address        = 32'd0;
    o_mem_write_data = 32'd0;
    o_mem_read       = 1'b0;
    o_mem_write      = 1'b0;
    o_busy           = 1'b0;
    o_done           = 1'b0;
    if (reset) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_next_state = (i_len == LEN_ZERO) ? ST_DONE : ST_READ;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_READ: begin
          o_req  = 1'b1;
          o_busy = 1'b1;
          if (i_grant) begin
            o_mem_read   = 1'b1;
            o_address    = r_src;
            w_next_state = ST_WRITE;
          end else begin
            w_next_state = ST_READ;
          end
        end
        ST_WRITE: begin
          o_req  = 1'b1;
          o_busy = 1'b1;
          if (i_grant) begin
            o_mem_write      = 1'b1;
            o_address        = r_dst;
            o_mem_write_data = r_buffer;
            w_next_state     = (r_remaining == LEN_ONE) ? ST_DONE : ST_READ;
          end else begin
            w_next_state = ST_WRITE;
          end
        end
        ST_DONE: begin
          o_busy       = 1'b1;
          o_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // State register plus transfer bookkeeping: pointers, word buffer and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_src       <= 32'd0;
      r_dst       <= 32'd0;
      r_buffer    <= 32'd0;
      r_remaining <= LEN_ZERO;
      r_count     <= LEN_ZERO;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_src       <= i_src & WORD_MASK;
            r_dst       <= i_dst & WORD_MASK;
            r_remaining <= i_len;
            r_count     <= LEN_ZERO;
          end
        end
        ST_READ: begin
          if (i_grant) begin
            r_buffer <= i_mem_read_data;
          end
        end
        ST_WRITE: begin
          if (i_grant) begin
            r_src       <= r_src + 32'd4;
            r_dst       <= r_dst + 32'd4;
            r_remaining <= r_remaining - LEN_ONE;
            r_count     <= r_count + LEN_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_copy_engine.sv
// tb_data_mem_copy_engine
// Directed bench with a 64-word behavioural data memory indexed by address[7:2].
module tb_data_mem_copy_engine;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [31:0] i_src;
  logic [31:0] i_dst;
  logic [7:0]  i_len;
  logic        i_grant;
  logic [31:0] mem_rdata;
  logic        o_req;
  logic [31:0] o_address;
  logic [31:0] o_mem_write_data;
  logic        o_mem_read;
  logic        o_mem_write;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_count;

  logic [31:0] mem [0:63];
  logic [31:0] rd_log [$];
  int          n_vec;
  int          n_err;

  data_mem_copy_engine #(.LEN_WIDTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_start          (i_start),
    .i_src            (i_src),
    .i_dst            (i_dst),
    .i_len            (i_len),
    .i_grant          (i_grant),
    .i_mem_read_data  (mem_rdata),
    .o_req            (o_req),
    .o_address        (o_address),
    .o_mem_write_data (o_mem_write_data),
    .o_mem_read       (o_mem_read),
    .o_mem_write      (o_mem_write),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_count          (o_count)
  );

  assign mem_rdata = mem[o_address[7:2]];

  // 10 time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: protocol checks, log reads, commit any granted write at the edge.
  task automatic step();
    logic        do_wr;
    logic [31:0] wa;
    logic [31:0] wd;
    #1;
    check("rw_exclusive", {31'd0, o_mem_read & o_mem_write}, 32'd0);
    check("strobe_without_grant", {31'd0, ~i_grant & (o_mem_read | o_mem_write)}, 32'd0);
    check("addr_align", {30'd0, o_address[1:0]}, 32'd0);
    if (o_mem_read) rd_log.push_back(o_address);
    do_wr = o_mem_write;
    wa    = o_address;
    wd    = o_mem_write_data;
    @(posedge clk);
    if (do_wr) mem[wa[7:2]] = wd;
    #1;
  endtask

  task automatic start(input logic [31:0] src, input logic [31:0] dst, input logic [7:0] len);
    rd_log.delete();
    i_src   = src;
    i_dst   = dst;
    i_len   = len;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_src   = 32'd0;
    i_dst   = 32'd0;
    i_len   = 8'd0;
  endtask

  // Run until o_done; cycle 1 is the cycle right after the start edge.
  task automatic run(input string tag, input logic [63:0] gnt_low, input bit busy_start,
                     input int exp_done);
    int cyc;
    cyc = 1;
    while (!o_done && cyc < 60) begin
      i_grant = ~gnt_low[cyc];
      if (busy_start) begin
        i_start = 1'b1;
        i_src   = 32'h0000_0020;
        i_dst   = 32'h0000_0060;
        i_len   = 8'd7;
      end
      step();
      cyc++;
    end
    check({tag, "_done_cycle"}, cyc, exp_done);
    i_grant = 1'b1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    i_start = 1'b0;
    i_src   = 32'd0;
    i_dst   = 32'd0;
    i_len   = 8'd0;
    i_grant = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;

    // reset state
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_req", {31'd0, o_req}, 32'd0);
    check("rst_addr", o_address, 32'd0);
    check("rst_wdata", o_mem_write_data, 32'd0);
    check("rst_strobes", {30'd0, o_mem_read, o_mem_write}, 32'd0);
    check("rst_busy_done", {30'd0, o_busy, o_done}, 32'd0);
    check("rst_count", {24'd0, o_count}, 32'd0);

    // basic copy: 4 words 0x00 -> 0x40
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    start(32'h0000_0000, 32'h0000_0040, 8'd4);
    run("basic", 64'd0, 1'b0, 9);
    check("basic_busy_in_done", {31'd0, o_busy}, 32'd1);
    check("basic_count", {24'd0, o_count}, 32'd4);
    step();
    check("basic_m16", mem[16], 32'h11);
    check("basic_m17", mem[17], 32'h22);
    check("basic_m18", mem[18], 32'h33);
    check("basic_m19", mem[19], 32'h44);
    check("basic_idle_after", {30'd0, o_busy, o_done}, 32'd0);
    check("basic_count_held", {24'd0, o_count}, 32'd4);

    // zero length
    start(32'h0000_0080, 32'h0000_0090, 8'd0);
    check("zero_done", {31'd0, o_done}, 32'd1);
    check("zero_busy", {31'd0, o_busy}, 32'd1);
    check("zero_no_strobe", {30'd0, o_mem_read, o_mem_write}, 32'd0);
    check("zero_count", {24'd0, o_count}, 32'd0);
    step();
    check("zero_idle", {31'd0, o_busy}, 32'd0);
    check("zero_no_reads", rd_log.size(), 32'd0);

    // grant stalls: low in cycles 1,2,3 (READ) and 5,6 (WRITE)
    start(32'h0000_0000, 32'h0000_0080, 8'd2);
    run("stall", 64'h6E, 1'b0, 10);
    check("stall_count", {24'd0, o_count}, 32'd2);
    step();
    check("stall_m32", mem[32], 32'h11);
    check("stall_m33", mem[33], 32'h22);

    // overlap with unaligned addresses: ascending propagation of word 0
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
    start(32'h0000_0001, 32'h0000_0006, 8'd3);
    run("overlap", 64'd0, 1'b0, 7);
    step();
    check("ovl_m0", mem[0], 32'd1);
    check("ovl_m1", mem[1], 32'd1);
    check("ovl_m2", mem[2], 32'd1);
    check("ovl_m3", mem[3], 32'd1);
    check("ovl_nreads", rd_log.size(), 32'd3);
    check("ovl_rd2", rd_log[2], 32'h0000_0008);

    // source address wrap
    mem[63] = 32'hAAAA_0001; mem[0] = 32'h5555_0002;
    start(32'hFFFF_FFFC, 32'h0000_00C0, 8'd2);
    run("wrap", 64'd0, 1'b0, 5);
    step();
    check("wrap_rd0", rd_log[0], 32'hFFFF_FFFC);
    check("wrap_rd1", rd_log[1], 32'h0000_0000);
    check("wrap_m48", mem[48], 32'hAAAA_0001);
    check("wrap_m49", mem[49], 32'h5555_0002);

    // reset in the 2nd WRITE cycle (cycle 4) of a 4-word copy
    mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2; mem[3] = 32'hA3;
    for (int i = 16; i < 20; i++) mem[i] = 32'd0;
    start(32'h0000_0000, 32'h0000_0040, 8'd4);
    for (int c = 1; c < 4; c++) step();
    reset = 1'b1;
    #1;
    check("rstmid_no_write", {31'd0, o_mem_write}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("rstmid_req", {31'd0, o_req}, 32'd0);
    check("rstmid_addr", o_address, 32'd0);
    check("rstmid_wdata", o_mem_write_data, 32'd0);
    check("rstmid_strobes", {30'd0, o_mem_read, o_mem_write}, 32'd0);
    check("rstmid_busy_done", {30'd0, o_busy, o_done}, 32'd0);
    check("rstmid_count", {24'd0, o_count}, 32'd0);
    check("rstmid_m16", mem[16], 32'hA0);
    check("rstmid_m17", mem[17], 32'd0);
    step();
    check("rstmid_stays_idle", {31'd0, o_busy}, 32'd0);

    // i_start pulsed throughout a busy 2-word transfer, including DONE
    mem[32] = 32'd0; mem[33] = 32'd0;
    start(32'h0000_0000, 32'h0000_0080, 8'd2);
    run("busystart", 64'd0, 1'b1, 5);
    check("busystart_count", {24'd0, o_count}, 32'd2);
    step();
    i_start = 1'b0;
    i_src   = 32'd0;
    i_dst   = 32'd0;
    i_len   = 8'd0;
    check("busystart_idle", {31'd0, o_busy}, 32'd0);
    check("busystart_m32", mem[32], 32'hA0);
    check("busystart_m33", mem[33], 32'hA1);
    check("busystart_nreads", rd_log.size(), 32'd2);
    check("busystart_rd1", rd_log[1], 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
